fifo_rr_arbiter: RTL and testbench

- Downstream consumer of the push/pop FIFOs.
- Drains NUM_PORTS input FIFOs (default 4) with a fair round-robin pop schedule and forwards each word to one output FIFO with push/data.
- Honours the output FIFO's almost-full backpressure and provides per-port grant counters for verification.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_rr_arbiter_rr_pick.sv | 42 ++++
 rtl/fifo_rr_arbiter.sv | 112 +++++++++++
 tb/tb_fifo_rr_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO-side blocks.
//   DEF_DATA_WIDTH : default width of every FIFO word
//   DEF_NUM_PORTS  : default number of input FIFOs drained by the arbiter
//   DEF_CNT_WIDTH  : default width of each per-port grant counter
//   word_t         : one FIFO word at the default width
//   arb_state_e    : arbiter activity state
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 10;
  localparam int DEF_NUM_PORTS  = 4;
  localparam int DEF_CNT_WIDTH  = 8;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder.
//   req : request vector, one bit per port
//   ptr : last granted port; the search starts at ptr+1 and wraps modulo N
//   gnt : one-hot grant (all zero when nothing requests)
//   idx : binary index of the granted port
//   any : high when some port was granted
module rr_pick
  import fifo_pkg::*;
#(
  parameter  int N  = DEF_NUM_PORTS,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin : pick
    int            cand;
    logic [IW-1:0] cand_idx;
    // NOTE: every output gets a default before the loop, so no path leaves
    // a value held over from the previous evaluation (no latch).
    gnt      = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // Offsets 1..N visit every port exactly once, the pointer's own port last.
    for (int k = 1; k <= N; k++) begin
      cand     = (int'(ptr) + k) % N;
      cand_idx = IW'(cand);
      if (!any && req[cand_idx]) begin
        any           = 1'b1;
        idx           = cand_idx;
        gnt[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Drains NUM_PORTS input FIFOs with a fair round-robin pop schedule and
// forwards each word into one output FIFO.
//   clk             : system clock, all state on the rising edge
//   reset           : asynchronous, active-low; clears all state
//   in_empty        : empty flag of each input FIFO
//   in_data         : head word of each input FIFO, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   pop             : one-hot registered read strobe to the input FIFOs
//   out_almost_full : almost-full flag of the output FIFO; blocks new pops
//   push            : registered write strobe to the output FIFO
//   data_out        : registered word written to the output FIFO
//   idle            : registered; no input has data and nothing is in flight
//   grant_cnt       : words forwarded per port, wrapping counters
// Pipeline: pop is registered at edge N, the word for that pop is taken from
// in_data at edge N+1, and push/data_out are valid in the following cycle.
module fifo_rr_arbiter
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            in_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_PORTS-1:0]            pop,
  input  logic                            out_almost_full,
  output logic                            push,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            idle,
  output logic [NUM_PORTS*CNT_WIDTH-1:0]  grant_cnt
);

  localparam int PW = $clog2(NUM_PORTS);

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         sel_q;
  logic [NUM_PORTS-1:0]  req;
  logic [NUM_PORTS-1:0]  pick_gnt;
  logic [PW-1:0]         pick_idx;
  logic                  pick_any;
  logic [DATA_WIDTH-1:0] words [NUM_PORTS];
  logic [CNT_WIDTH-1:0]  cnt   [NUM_PORTS];
  arb_state_e            state;

  // Almost-full masks every request; the words already popped still drain
  // because the threshold leaves room for the two in-flight stages.
  assign req = out_almost_full ? '0 : ~in_empty;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign words[i]                            = in_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt[i];
  end

  rr_pick #(.N(NUM_PORTS)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value (push <= |pop uses the old pop).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the counter array is a handful of flops, not a RAM, so it is
      // cleared here along with everything else.
      pop      <= '0;
      sel_q    <= '0;
      ptr      <= PW'(NUM_PORTS - 1);
      push     <= 1'b0;
      data_out <= '0;
      state    <= ST_IDLE;
      idle     <= 1'b1;
      for (int i = 0; i < NUM_PORTS; i++) cnt[i] <= '0;
    end else begin
      // Stage 0/1: pop and its source index are registered together.
      pop   <= pick_gnt;
      sel_q <= pick_idx;
      if (pick_any) ptr <= pick_idx;

      // Stage 2: the popped word is on in_data while pop is high.
      push <= |pop;
      if (|pop) begin
        data_out   <= words[sel_q];
        cnt[sel_q] <= cnt[sel_q] + 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (!(&in_empty)) begin
            state <= ST_ACTIVE;
            idle  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          // pop and push are the two in-flight stages.
          if ((&in_empty) && !pick_any && !(|pop) && !push) begin
            state <= ST_IDLE;
            idle  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          idle  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter. Four show-ahead input FIFOs are modelled
// with queues; the expected output order is pushed to a scoreboard when words
// are loaded and popped when the DUT pushes.
module tb_fifo_rr_arbiter;
  import fifo_pkg::*;

  localparam int DW = 10;
  localparam int NP = 4;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NP-1:0]    in_empty = '1;
  logic [NP*DW-1:0] in_data = '0;
  logic [NP-1:0]    pop;
  logic             out_almost_full = 1'b0;
  logic             push;
  logic [DW-1:0]    data_out;
  logic             idle;
  logic [NP*CW-1:0] grant_cnt;

  int errors = 0;
  int checks = 0;

  word_t         fq [NP][$];
  word_t         exp_data_q [$];
  logic [CW-1:0] exp_cnt [NP];
  logic [NP-1:0] prev_pop = '0;

  fifo_rr_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP), .CNT_WIDTH(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .pop             (pop),
    .out_almost_full (out_almost_full),
    .push            (push),
    .data_out        (data_out),
    .idle            (idle),
    .grant_cnt       (grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Input FIFO model and output monitor, both away from the rising edge.
  // A pop is taken out of its FIFO at the rising edge after it was issued;
  // the empty flag already accounts for the pop currently on the wire.
  always @(negedge clk) begin
    int sz;
    word_t w;
    for (int i = 0; i < NP; i++) begin
      if (prev_pop[i]) begin
        chk($sformatf("fifo%0d_underflow", i), 64'(fq[i].size() > 0), 64'd1);
        if (fq[i].size() > 0) w = fq[i].pop_front();
      end
    end
    prev_pop = pop;
    for (int i = 0; i < NP; i++) begin
      sz = fq[i].size();
      in_empty[i] = (sz - int'(pop[i])) <= 0;
      in_data[i*DW +: DW] = (sz > 0) ? fq[i][0] : '0;
    end
    chk("pop_onehot", 64'($onehot0(pop)), 64'd1);
    if (push) begin
      chk("push_expected", 64'(exp_data_q.size() != 0), 64'd1);
      if (exp_data_q.size() != 0) begin
        w = exp_data_q.pop_front();
        chk("data_out", 64'(data_out), 64'(w));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int p, input word_t w);
    fq[p].push_back(w);
    exp_data_q.push_back(w);
    exp_cnt[p] = exp_cnt[p] + 1'b1;
  endtask

  task automatic wait_pop(input string tag, input int max);
    for (int i = 0; i < max && pop == '0; i++) step();
    chk({tag, "_pop_seen"}, 64'(|pop), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max && idle !== 1'b1; i++) step();
    chk({tag, "_idle"}, 64'(idle), 64'd1);
    chk({tag, "_sb_empty"}, 64'(exp_data_q.size()), 64'd0);
  endtask

  task automatic check_cnts(input string tag);
    for (int p = 0; p < NP; p++)
      chk($sformatf("%s_grant_cnt%0d", tag, p), 64'(grant_cnt[p*CW +: CW]), 64'(exp_cnt[p]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
    step();
    step();

    // Reset held with every FIFO non-empty.
    for (int p = 0; p < NP; p++) load(p, word_t'(10'h100 + p));
    step();
    step();
    chk("rst_pop", 64'(pop), 64'd0);
    chk("rst_push", 64'(push), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_idle", 64'(idle), 64'd1);
    chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
    reset = 1'b1;
    step();
    chk("rst_first_pop", 64'(pop), 64'b0001);
    wait_idle("rst", 20);
    check_cnts("rst");

    // Fairness: three words per port, strict rotation 0,1,2,3.
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < NP; p++) load(p, word_t'(p * 16 + r));
    wait_pop("fair", 10);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("fair_pop%0d", i), 64'(pop), 64'(1 << (i % NP)));
      step();
    end
    chk("fair_pop_done", 64'(pop), 64'd0);
    wait_idle("fair", 20);
    check_cnts("fair");

    // Single non-empty port drained back to back.
    for (int i = 0; i < 14; i++) load(2, word_t'(10'h090 + i));
    wait_pop("single", 10);
    for (int i = 0; i < 14; i++) begin
      chk($sformatf("single_pop%0d", i), 64'(pop), 64'b0100);
      chk($sformatf("single_push%0d", i), 64'(push), 64'(i != 0));
      step();
    end
    chk("single_pop_done", 64'(pop), 64'd0);
    chk("single_last_push", 64'(push), 64'd1);
    wait_idle("single", 20);
    check_cnts("single");

    // Backpressure: pointer sits on port 2, so rotation starts at port 3.
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NP; k++) load((k + 3) % NP, word_t'(10'h200 + ((k + 3) % NP) * 16 + r));
    wait_pop("bp", 10);
    chk("bp_pop_a", 64'(pop), 64'b1000);
    step();
    chk("bp_pop_b", 64'(pop), 64'b0001);
    out_almost_full = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("bp_hold_pop%0d", i), 64'(pop), 64'd0);
    end
    chk("bp_inflight_pushed", 64'(exp_data_q.size()), 64'd6);
    chk("bp_idle_low", 64'(idle), 64'd0);
    out_almost_full = 1'b0;
    step();
    chk("bp_resume_pop", 64'(pop), 64'b0010);
    wait_idle("bp", 30);
    check_cnts("bp");

    // Asynchronous reset while port 0 has one word pushing and one popped.
    fq[0].push_back(word_t'(10'h2A0));
    fq[0].push_back(word_t'(10'h2A1));
    exp_data_q.push_back(word_t'(10'h2A0));
    exp_data_q.push_back(word_t'(10'h2A1));
    wait_pop("mid", 10);
    chk("mid_pop_a", 64'(pop), 64'b0001);
    step();
    chk("mid_pop_b", 64'(pop), 64'b0001);
    chk("mid_push_a", 64'(push), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_push", 64'(push), 64'd0);
    chk("mid_rst_pop", 64'(pop), 64'd0);
    chk("mid_rst_data_out", 64'(data_out), 64'd0);
    chk("mid_rst_idle", 64'(idle), 64'd1);
    // 2A0 is lost with the pipeline; 2A1 was never taken from the FIFO.
    exp_data_q.delete();
    exp_data_q.push_back(word_t'(10'h2A1));
    for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
    exp_cnt[0] = 8'd1;
    load(1, word_t'(10'h2B0));
    step();
    step();
    chk("mid_rst_hold_push", 64'(push), 64'd0);
    reset = 1'b1;
    step();
    chk("mid_restart_pop0", 64'(pop), 64'b0001);
    chk("mid_no_stale_push", 64'(push), 64'd0);
    step();
    chk("mid_restart_pop1", 64'(pop), 64'b0010);
    wait_idle("mid", 20);
    check_cnts("mid");

    // Counter wrap on port 1 from a clean reset.
    reset = 1'b0;
    step();
    for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
    reset = 1'b1;
    step();
    for (int i = 0; i < 255; i++) load(1, word_t'(i));
    wait_pop("wrap_a", 10);
    wait_idle("wrap_a", 400);
    chk("wrap_cnt255", 64'(grant_cnt[1*CW +: CW]), 64'd255);
    load(1, word_t'(10'h3FF));
    wait_pop("wrap_b", 10);
    wait_idle("wrap_b", 20);
    chk("wrap_cnt0", 64'(grant_cnt[1*CW +: CW]), 64'd0);
    check_cnts("wrap");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
